// File: rtl/frame_buffer_scheduler.sv
// frame_buffer_scheduler
// Owns the single-port character frame buffer RAM. Display scan reads take
// priority; parser writes wait in a small FIFO and drain in idle RAM cycles.
// The scan walks the frame column by column, one burst of ROWS reads per
// SCAN_DIV-clock column slot, and returns pixels two cycles after each read.
module frame_buffer_scheduler #(
    parameter int COLS       = 40,
    parameter int ROWS       = 15,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int SCAN_DIV   = 128
) (
    input  logic              master_clk,
    input  logic              reset_n,
    input  logic              wr_valid,
    input  logic [7:0]        wr_col,
    input  logic [7:0]        wr_row,
    input  logic [DATA_W-1:0] wr_char,
    output logic              wr_ready,
    output logic              wr_err,
    input  logic              frame_start,
    output logic              scan_busy,
    output logic              frame_done,
    output logic              pix_valid,
    output logic [7:0]        pix_col,
    output logic [7:0]        pix_row,
    output logic [DATA_W-1:0] pix_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int TICK_W = $clog2(SCAN_DIV);

    localparam logic [7:0]        LAST_COL  = 8'(COLS - 1);
    localparam logic [7:0]        LAST_ROW  = 8'(ROWS - 1);
    localparam logic [7:0]        COLS_L    = 8'(COLS);
    localparam logic [7:0]        ROWS_L    = 8'(ROWS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    // Column-major linear address, kept at full ADDR_W width.
    function automatic logic [ADDR_W-1:0] addr_of(input logic [7:0] c, input logic [7:0] r);
        return ADDR_W'(c) * ADDR_W'(ROWS) + ADDR_W'(r);
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_WAIT, S_DRAIN} state_t;

    state_t            state, state_nxt;
    logic [7:0]        scan_col, scan_row, scan_col_nxt, scan_row_nxt;
    logic [TICK_W-1:0] tick, tick_nxt;
    logic              issue_rd, issue_last;

    logic              vld_p0, last_p0, vld_p1, last_p1;
    logic [7:0]        col_p0, row_p0, col_p1, row_p1;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr, rptr;
    logic [CNT_W-1:0]  count;
    logic              in_range, push, pop;

    assign in_range  = (wr_col < COLS_L) && (wr_row < ROWS_L);
    assign wr_ready  = (count < CNT_FULL);
    assign push      = wr_valid && wr_ready && in_range;
    // A queued write only gets the RAM when the scan is not bursting.
    assign pop       = (state != S_BURST) && (count != '0);
    assign scan_busy = (state != S_IDLE);
    assign vld_p0    = mem_re;

    // Scan sequencer: state, current column/row and slot tick counter.
    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            scan_col <= '0;
            scan_row <= '0;
            tick     <= '0;
        end else begin
            state    <= state_nxt;
            scan_col <= scan_col_nxt;
            scan_row <= scan_row_nxt;
            tick     <= tick_nxt;
        end
    end

    // Next-state logic; the tick counts from the first burst cycle of each slot.
    always_comb begin
        state_nxt    = state;
        scan_col_nxt = scan_col;
        scan_row_nxt = scan_row;
        tick_nxt     = tick + TICK_W'(1);
        issue_rd     = 1'b0;
        issue_last   = 1'b0;
        case (state)
            S_IDLE: begin
                tick_nxt = '0;
                if (frame_start) begin
                    state_nxt    = S_BURST;
                    scan_col_nxt = '0;
                    scan_row_nxt = '0;
                end
            end
            S_BURST: begin
                issue_rd = 1'b1;
                if (scan_row == LAST_ROW) begin
                    scan_row_nxt = '0;
                    issue_last   = (scan_col == LAST_COL);
                    state_nxt    = (scan_col == LAST_COL) ? S_DRAIN : S_WAIT;
                end else begin
                    scan_row_nxt = scan_row + 8'd1;
                end
            end
            S_WAIT: begin
                if (tick == TICK_LAST) begin
                    tick_nxt     = '0;
                    scan_col_nxt = scan_col + 8'd1;
                    state_nxt    = S_BURST;
                end
            end
            S_DRAIN: begin
                tick_nxt = '0;
                if (last_p1) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Write queue storage; contents are don't-care while count is zero.
    always_ff @(posedge master_clk) begin
        if (push) begin
            fifo_addr[wptr] <= addr_of(wr_col, wr_row);
            fifo_data[wptr] <= wr_char;
        end
    end

    // Write queue pointers, occupancy and out-of-range error pulse.
    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_valid && wr_ready && !in_range;
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // RAM port register (p0): scan read or queued write, never both.
    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_re <= issue_rd;
            mem_we <= pop;
            if (issue_rd) begin
                mem_addr <= addr_of(scan_col, scan_row);
            end else if (pop) begin
                mem_addr  <= fifo_addr[rptr];
                mem_wdata <= fifo_data[rptr];
            end
        end
    end

    // Pixel pipeline control flags (p0 -> p1), cleared by reset.
    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            last_p0 <= 1'b0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            last_p0 <= issue_last;
            vld_p1  <= vld_p0;
            last_p1 <= last_p0;
        end
    end

    // Pixel coordinates ride alongside the read (p0 -> p1).
    always_ff @(posedge master_clk) begin
        if (issue_rd) begin
            col_p0 <= scan_col;
            row_p0 <= scan_row;
        end
        if (vld_p0) begin
            col_p1 <= col_p0;
            row_p1 <= row_p0;
        end
    end

    // Pixel output stage (p2): capture RAM data with its coordinates.
    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            pix_col    <= '0;
            pix_row    <= '0;
            pix_data   <= '0;
        end else begin
            pix_valid  <= vld_p1;
            frame_done <= last_p1;
            if (vld_p1) begin
                pix_col  <= col_p1;
                pix_row  <= row_p1;
                pix_data <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Bench for frame_buffer_scheduler: RAM model, event monitor and a
// transaction-level reference (expected write list, expected RAM image,
// expected pixel timeline computed from column/row arithmetic).
module tb_frame_buffer_scheduler;

    localparam int COLS       = 40;
    localparam int ROWS       = 15;
    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 10;
    localparam int FIFO_DEPTH = 4;
    localparam int SCAN_DIV   = 128;
    localparam int NPIX       = COLS * ROWS;

    typedef struct {
        int   cyc;
        int   addr;
        int   data;
        logic done;
        int   col;
        int   row;
    } ev_t;

    logic              master_clk = 1'b0;
    logic              reset_n;
    logic              wr_valid;
    logic [7:0]        wr_col;
    logic [7:0]        wr_row;
    logic [DATA_W-1:0] wr_char;
    logic              wr_ready;
    logic              wr_err;
    logic              frame_start;
    logic              scan_busy;
    logic              frame_done;
    logic              pix_valid;
    logic [7:0]        pix_col;
    logic [7:0]        pix_row;
    logic [DATA_W-1:0] pix_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int both_cnt = 0;
    int done_cnt = 0;
    int orphan_done = 0;

    ev_t mon_we[$];
    ev_t mon_re[$];
    ev_t mon_pix[$];
    ev_t exp_we[$];
    int  exp_ram [NPIX];

    logic [7:0] ram [1024];
    logic       ram_ready = 1'b0;

    frame_buffer_scheduler #(
        .COLS(COLS), .ROWS(ROWS), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .FIFO_DEPTH(FIFO_DEPTH), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .master_clk(master_clk), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_col(wr_col), .wr_row(wr_row), .wr_char(wr_char),
        .wr_ready(wr_ready), .wr_err(wr_err),
        .frame_start(frame_start), .scan_busy(scan_busy), .frame_done(frame_done),
        .pix_valid(pix_valid), .pix_col(pix_col), .pix_row(pix_row), .pix_data(pix_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 master_clk = ~master_clk;

    // Cycle counter: value after the most recent rising edge.
    always @(posedge master_clk) cyc <= cyc + 1;

    // Synchronous RAM with registered read; preloaded with RAM[a] = a[7:0].
    always @(posedge master_clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 8'(i);
            ram_ready <= 1'b1;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            if (mem_re) mem_rdata <= ram[mem_addr];
        end
    end

    // Event recorder, sampled on the falling edge.
    always @(negedge master_clk) begin
        if (mem_we && mem_re) both_cnt++;
        if (mem_we) mon_we.push_back('{cyc, int'(mem_addr), int'(mem_wdata), 1'b0, 0, 0});
        if (mem_re) mon_re.push_back('{cyc, int'(mem_addr), 0, 1'b0, 0, 0});
        if (pix_valid) mon_pix.push_back('{cyc, 0, int'(pix_data), frame_done, int'(pix_col), int'(pix_row)});
        if (frame_done) done_cnt++;
        if (frame_done && !pix_valid) orphan_done++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge master_clk);
        #1;
    endtask

    // One-cycle write request while the queue is known to be draining freely.
    task automatic drive_write(input int c, input int r, input int ch);
        logic ok;
        ok       = (c < COLS) && (r < ROWS);
        wr_valid = 1'b1;
        wr_col   = 8'(c);
        wr_row   = 8'(r);
        wr_char  = 8'(ch);
        check("wr_ready_idle", wr_ready, 1);
        step();
        check("wr_err", wr_err, ok ? 0 : 1);
        if (ok) begin
            exp_we.push_back('{cyc + 1, c * ROWS + r, ch, 1'b0, 0, 0});
            exp_ram[c * ROWS + r] = ch;
        end
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_count"}, mon_we.size(), exp_we.size());
        for (int i = 0; i < exp_we.size() && i < mon_we.size(); i++) begin
            check({tag, "_cyc"},  mon_we[i].cyc,  exp_we[i].cyc);
            check({tag, "_addr"}, mon_we[i].addr, exp_we[i].addr);
            check({tag, "_data"}, mon_we[i].data, exp_we[i].data);
        end
        mon_we.delete();
        exp_we.delete();
    endtask

    int cyc_e;
    int guard;
    int c, r, ch;

    initial begin
        for (int i = 0; i < NPIX; i++) exp_ram[i] = i & 255;
        reset_n     = 1'b0;
        wr_valid    = 1'b0;
        wr_col      = '0;
        wr_row      = '0;
        wr_char     = '0;
        frame_start = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_wr_ready", wr_ready, 1);
        check("rst_wr_err", wr_err, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_re", mem_re, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_scan_busy", scan_busy, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_frame_done", frame_done, 0);
        reset_n = 1'b1;
        repeat (2) step();

        // Single idle write lands on the RAM port one cycle after acceptance
        drive_write(3, 5, 8'h61);
        wr_valid = 1'b0;
        check("t1_we_not_yet", mem_we, 0);
        step();
        check("t1_we", mem_we, 1);
        check("t1_addr", mem_addr, 50);
        check("t1_wdata", mem_wdata, 8'h61);
        check("t1_re", mem_re, 0);
        step();
        check("t1_we_single", mem_we, 0);
        compare_writes("t1");

        // Out-of-range coordinates are dropped with an error pulse
        drive_write(COLS, 0, 8'h11);
        wr_valid = 1'b0;
        step();
        check("t2_err_pulse_end", wr_err, 0);
        drive_write(0, ROWS, 8'h22);
        wr_valid = 1'b0;
        step();
        check("t2_ready_kept", wr_ready, 1);
        step();
        compare_writes("t2");

        // Random back-to-back writes, some out of range
        for (int i = 0; i < 24; i++) begin
            drive_write($urandom_range(0, COLS + 4), $urandom_range(0, ROWS + 1), $urandom_range(0, 255));
        end
        wr_valid = 1'b0;
        repeat (3) step();
        compare_writes("rand_idle");

        // Full frame scan with a stray frame_start in the middle
        mon_re.delete();
        mon_pix.delete();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        cyc_e = cyc;
        check("t3_busy", scan_busy, 1);
        repeat (2000) step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("t5_busy_ignored", scan_busy, 1);
        guard = 0;
        while (scan_busy === 1'b1 && guard < 6000) begin
            step();
            guard++;
        end
        check("t3_frame_timeout", (guard < 6000) ? 1 : 0, 1);
        repeat (300) step();
        check("t3_re_count", mon_re.size(), NPIX);
        check("t3_pix_count", mon_pix.size(), NPIX);
        for (int k = 0; k < NPIX && k < mon_re.size(); k++) begin
            check("t3_re_cyc", mon_re[k].cyc, cyc_e + 1 + (k / ROWS) * SCAN_DIV + (k % ROWS));
            check("t3_re_addr", mon_re[k].addr, k);
        end
        for (int k = 0; k < NPIX && k < mon_pix.size(); k++) begin
            check("t3_pix_cyc", mon_pix[k].cyc, cyc_e + 3 + (k / ROWS) * SCAN_DIV + (k % ROWS));
            check("t3_pix_col", mon_pix[k].col, k / ROWS);
            check("t3_pix_row", mon_pix[k].row, k % ROWS);
            check("t3_pix_data", mon_pix[k].data, exp_ram[k]);
            check("t3_pix_done", mon_pix[k].done, (k == NPIX - 1) ? 1 : 0);
        end
        check("t5_one_frame_done", done_cnt, 1);
        check("t3_no_orphan_done", orphan_done, 0);
        check("t3_idle_after", scan_busy, 0);

        // Five writes during a burst: four queued, drained after the burst
        mon_re.delete();
        mon_pix.delete();
        mon_we.delete();
        exp_we.delete();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        cyc_e = cyc;
        for (int i = 0; i < 5; i++) begin
            c  = $urandom_range(0, COLS - 1);
            r  = $urandom_range(0, ROWS - 1);
            ch = $urandom_range(0, 255);
            wr_valid = 1'b1;
            wr_col   = 8'(c);
            wr_row   = 8'(r);
            wr_char  = 8'(ch);
            check("t4_wr_ready", wr_ready, (i < FIFO_DEPTH) ? 1 : 0);
            if (i < FIFO_DEPTH) begin
                exp_we.push_back('{cyc_e + ROWS + 1 + i, c * ROWS + r, ch, 1'b0, 0, 0});
                exp_ram[c * ROWS + r] = ch;
            end
            step();
        end
        wr_valid = 1'b0;
        check("t4_re_in_burst", mem_re, 1);
        check("t4_full_ready", wr_ready, 0);
        repeat (20) step();
        compare_writes("t4_drain");
        check("t4_ready_back", wr_ready, 1);

        // Reset in the middle of the next burst with two writes queued
        repeat (105) step();
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1;
            wr_col   = 8'($urandom_range(0, COLS - 1));
            wr_row   = 8'($urandom_range(0, ROWS - 1));
            wr_char  = 8'($urandom_range(0, 255));
            check("t6_wr_ready", wr_ready, 1);
            step();
        end
        wr_valid = 1'b0;
        check("t6_re_before", mem_re, 1);
        check("t6_we_before", mem_we, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_re_async", mem_re, 0);
        check("t6_we_async", mem_we, 0);
        check("t6_busy_async", scan_busy, 0);
        check("t6_pix_async", pix_valid, 0);
        check("t6_ready_async", wr_ready, 1);
        mon_we.delete();
        mon_re.delete();
        mon_pix.delete();
        done_cnt = 0;
        repeat (2) step();
        reset_n = 1'b1;
        repeat (40) step();
        check("t6_no_stale_write", mon_we.size(), 0);
        check("t6_no_scan", mon_re.size(), 0);
        check("t6_no_pix", mon_pix.size(), 0);
        check("t6_no_done", done_cnt, 0);
        check("t6_idle", scan_busy, 0);
        check("t6_ready", wr_ready, 1);
        drive_write(7, 2, 8'h5A);
        wr_valid = 1'b0;
        repeat (2) step();
        compare_writes("t6_post");

        check("never_we_and_re", both_cnt, 0);
        check("no_orphan_done", orphan_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
